tmr_xor_accumulator: RTL

//   Parametrised, triplicated XOR-accumulator state machine. It generalises the single-bit

---
 rtl/tmr_xor_accumulator.sv | 77 +++++++
 1 files changed

// File: rtl/tmr_xor_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_xor_accumulator
//  Description : Triplicated WIDTH-bit XOR accumulator with bitwise majority
//                vote, optional per-cycle scrubbing, copy-disagreement flag,
//                saturating error counter and a test-only upset injector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmr_xor_accumulator #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 ERRCNT_W  = 4,
    parameter bit                 SCRUB     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [WIDTH-1:0]      in,
    input  logic [2:0]            inj_sel,
    input  logic [WIDTH-1:0]      inj_mask,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      out,
    output logic                  err,
    output logic [ERRCNT_W-1:0]   err_cnt
);

    localparam logic [ERRCNT_W-1:0] c_ERR_MAX = '1;

    logic [WIDTH-1:0]    r_copy [3];
    logic                r_err;
    logic [ERRCNT_W-1:0] r_errCnt;

    logic [WIDTH-1:0]    w_voted;
    logic [WIDTH-1:0]    w_nxt;
    logic                w_mm;

    assign w_voted = (r_copy[0] & r_copy[1]) | (r_copy[1] & r_copy[2]) | (r_copy[0] & r_copy[2]);
    assign w_mm    = (r_copy[0] != r_copy[1]) | (r_copy[1] != r_copy[2]) | (r_copy[0] != r_copy[2]);
    assign w_nxt   = en ? (w_voted ^ in) : w_voted;

    // Without scrubbing an idle copy keeps its own value, so an upset persists until the next accumulate.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) begin
                r_copy[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (SCRUB || en) begin
                    r_copy[i] <= w_nxt ^ (inj_sel[i] ? inj_mask : '0);
                end else begin
                    r_copy[i] <= r_copy[i] ^ (inj_sel[i] ? inj_mask : '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err    <= 1'b0;
            r_errCnt <= '0;
        end else begin
            r_err <= w_mm;
            if (err_clr) begin
                r_errCnt <= '0;
            end else if (w_mm && (r_errCnt != c_ERR_MAX)) begin
                r_errCnt <= r_errCnt + 1'b1;
            end
        end
    end

    assign out     = w_voted;
    assign err     = r_err;
    assign err_cnt = r_errCnt;

endmodule
`default_nettype wire
